// File: rtl/l2_ram_multi_bank_pipe.sv
// Word-interleaved multi-bank L2 RAM with per-bank TCDM ports, range checking and a
// RD_LATENCY-deep response pipeline. Define L2_INIT_ZERO_EN to zero all banks after reset.
module l2_ram_multi_bank_pipe #(
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_WORDS = 32768,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  test_mode_i,
  input  logic [NB_BANKS-1:0]                   req_i,
  input  logic [NB_BANKS-1:0][31:0]             add_i,
  input  logic [NB_BANKS-1:0]                   wen_i,
  input  logic [NB_BANKS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [NB_BANKS-1:0]                   gnt_o,
  output logic [NB_BANKS-1:0]                   r_valid_o,
  output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   r_rdata_o,
  output logic [NB_BANKS-1:0]                   r_opc_o,
  output logic                                  init_done_o
);

  localparam int unsigned BeWidth    = DATA_WIDTH / 8;
  localparam int unsigned BankBits   = $clog2(NB_BANKS);
  localparam int unsigned WordBits   = $clog2(BANK_WORDS);
  localparam logic [32:0] RangeBytes = 33'(NB_BANKS) * 33'(BANK_WORDS) * 33'd4;

  logic                init_done_q;
  logic                init_we;
  logic [WordBits-1:0] init_addr;

`ifdef L2_INIT_ZERO_EN
  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e              state_q;
  logic [WordBits-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (test_mode_i || cnt_q == WordBits'(BANK_WORDS - 1)) begin
            state_q     <= StReady;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + WordBits'(1);
          end
        end
        StReady: init_done_q <= 1'b1;
        default: state_q <= StInit;
      endcase
    end
  end

  // Every bank is swept in parallel, one word per cycle.
  assign init_we   = (state_q == StInit) && !test_mode_i && !rst_i;
  assign init_addr = cnt_q;
`else
  logic unused_test_mode;

  always_ff @(posedge clk_i) begin
    if (rst_i) init_done_q <= 1'b0;
    else       init_done_q <= 1'b1;
  end

  assign init_we          = 1'b0;
  assign init_addr        = '0;
  assign unused_test_mode = test_mode_i;
`endif

  assign init_done_o = init_done_q;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [31:0]           off;
    logic                  oor;
    logic [WordBits-1:0]   idx;
    logic [DATA_WIDTH-1:0] mem_q [BANK_WORDS];
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] opc_q;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

    // Addresses below the base wrap to large offsets and are caught by the same compare.
    assign off = add_i[b] - BASE_ADDR;
    assign oor = {1'b0, off} >= RangeBytes;
    assign idx = off[2+BankBits +: WordBits];

    assign gnt_o[b] = req_i[b] & init_done_q;

    always_ff @(posedge clk_i) begin
      if (init_we) begin
        mem_q[init_addr] <= '0;
      end else if (gnt_o[b] && !wen_i[b] && !oor) begin
        for (int k = 0; k < BeWidth; k++) begin
          if (be_i[b][k]) mem_q[idx][8*k +: 8] <= wdata_i[b][8*k +: 8];
        end
      end
    end

    // Stage 0 of data_q models the macro output register; later stages add latency.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
        opc_q <= '0;
        for (int s = 0; s < RD_LATENCY; s++) data_q[s] <= '0;
      end else begin
        vld_q[0] <= gnt_o[b];
        opc_q[0] <= gnt_o[b] & oor;
        if (gnt_o[b] && wen_i[b]) data_q[0] <= oor ? '0 : mem_q[idx];
        for (int s = 1; s < RD_LATENCY; s++) begin
          vld_q[s]  <= vld_q[s-1];
          opc_q[s]  <= opc_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
    end

    assign r_valid_o[b] = vld_q[RD_LATENCY-1];
    assign r_opc_o[b]   = opc_q[RD_LATENCY-1];
    assign r_rdata_o[b] = data_q[RD_LATENCY-1];
  end

endmodule

// File: tb/tb_l2_ram_multi_bank_pipe.sv
// Randomised and directed bench for l2_ram_multi_bank_pipe against a word-array memory model
// with fixed-latency expected responses. Zero-init checks are compiled in with L2_INIT_ZERO_EN.
module tb_l2_ram_multi_bank_pipe;
  localparam int          NB   = 4;
  localparam int          BW   = 16;
  localparam int          DW   = 32;
  localparam int          RL   = 2;
  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam logic [31:0] SPAN = 32'(NB * BW * 4);

  logic clk = 1'b0;
  logic rst, tm, idone;
  logic [NB-1:0]        req, wen, gnt, rv, ropc;
  logic [NB-1:0][31:0]  add, wdata, rdata;
  logic [NB-1:0][3:0]   be;

  l2_ram_multi_bank_pipe #(
    .NB_BANKS(NB), .BANK_WORDS(BW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .RD_LATENCY(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .test_mode_i(tm), .req_i(req), .add_i(add), .wen_i(wen),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt), .r_valid_o(rv), .r_rdata_o(rdata),
    .r_opc_o(ropc), .init_done_o(idone)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          opc;
    bit          chk;
    logic [31:0] data;
  } resp_t;

  resp_t       ring [8][NB];
  logic [31:0] mem_m [NB][BW];
  bit          known [NB][BW];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    req = '0;
  endtask

  // Drives one request on bank b and records the response it must produce RL cycles later.
  task automatic put(input int b, input logic [31:0] a, input bit rd, input logic [3:0] bb,
                     input logic [31:0] d);
    logic [31:0] off;
    int          idx;
    resp_t       r;
    req[b] = 1'b1; add[b] = a; wen[b] = rd; be[b] = bb; wdata[b] = d;
    off = a - BASE;
    r.v = 1'b1; r.opc = (off >= SPAN); r.chk = rd; r.data = '0;
    if (!r.opc) begin
      idx = (int'(off) / 4 / NB) % BW;
      if (rd) begin
        r.chk  = known[b][idx];
        r.data = mem_m[b][idx];
      end else begin
        for (int k = 0; k < 4; k++) if (bb[k]) mem_m[b][idx][8*k +: 8] = d[8*k +: 8];
        if (bb == 4'hF) known[b][idx] = 1'b1;
      end
    end
    ring[(cyc + RL) % 8][b] = r;
  endtask

  task automatic clear_ring();
    for (int s = 0; s < 8; s++) for (int b = 0; b < NB; b++) ring[s][b].v = 1'b0;
  endtask

  function automatic logic [31:0] waddr(input int idx, input int b);
    return BASE + 32'((idx * NB + b) * 4);
  endfunction

  task automatic test_reset();
    rst = 1'b1; tm = 1'b0; wen = '1; be = '1; wdata = '0; add = {NB{BASE}};
    req = '1; tick();
    req = '1; tick();
    req = '1; #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    checks++;
    if (rv !== '0 || ropc !== '0 || rdata !== '0 || idone !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs: valid=%b opc=%b data=%h done=%b, want all 0", rv, ropc, rdata,
               idone);
    end
    rst = 1'b0; req = '0;
`ifdef L2_INIT_ZERO_EN
    for (int k = 1; k <= BW; k++) begin
      tick();
      checks++;
      if (idone !== (k == BW)) begin
        errors++; $display("FAIL init_time cycle %0d: done=%b want %b", k, idone, k == BW);
      end
    end
    for (int b = 0; b < NB; b++) for (int i = 0; i < BW; i++) begin
      mem_m[b][i] = '0; known[b][i] = 1'b1;
    end
`else
    tick();
    checks++; if (idone !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", idone); end
`endif
    req = 4'b1010; #1;
    checks++; if (gnt !== 4'b1010) begin errors++; $display("FAIL gnt_comb: got %b want 1010", gnt); end
    req = '0;
  endtask

`ifdef L2_INIT_ZERO_EN
  task automatic test_zero_init();
    for (int t = 1; t <= BW + RL; t++) begin
      if (t <= BW) for (int b = 0; b < NB; b++) put(b, waddr(t - 1, b), 1'b1, 4'hF, '0);
      tick();
      if (t >= RL && t - RL < BW) begin
        checks++;
        if (rv !== '1 || rdata !== '0 || ropc !== '0) begin
          errors++;
          $display("FAIL zero_init word %0d: valid=%b data=%h opc=%b, want 1111/0/0", t - RL, rv,
                   rdata, ropc);
        end
      end
    end
    tick();
  endtask
`endif

  task automatic test_interleave();
    put(1, BASE + 32'h14, 1'b0, 4'hF, 32'hDEAD_BEEF); #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wr_gnt: got %b want 0010", gnt); end
    tick();
    put(1, BASE + 32'h14, 1'b1, 4'hF, '0);
    tick();
    checks++;
    if (rv !== 4'b0010 || ropc !== '0) begin
      errors++; $display("FAIL wr_resp: valid=%b opc=%b want 0010/0000", rv, ropc);
    end
    tick();
    checks++;
    if (rv !== 4'b0010 || ropc !== '0 || rdata[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_resp: valid=%b opc=%b data=%h want 0010/0000/deadbeef", rv, ropc, rdata[1]);
    end
    tick();
    checks++; if (rv !== '0) begin errors++; $display("FAIL single_pulse: valid=%b want 0", rv); end
  endtask

  task automatic test_byte_enable();
    put(2, BASE + 32'h28, 1'b0, 4'hF, 32'hFFFF_FFFF); tick();
    put(2, BASE + 32'h28, 1'b0, 4'b0101, 32'h1234_5678); tick();
    put(2, BASE + 32'h28, 1'b1, 4'hF, '0); tick();
    tick();
    checks++;
    if (rv !== 4'b0100 || ropc[2] !== 1'b0 || rdata[2] !== 32'hFF34_FF78) begin
      errors++;
      $display("FAIL byte_en: valid=%b opc=%b data=%h want 0100/0/ff34ff78", rv, ropc[2], rdata[2]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    put(0, BASE, 1'b0, 4'hF, 32'hA5A5_A5A5);
    put(3, BASE + 32'hFC, 1'b0, 4'hF, 32'h5A5A_C3C3);
    tick();
    put(0, BASE + SPAN, 1'b0, 4'hF, '0);
    put(3, BASE - 32'd4, 1'b0, 4'hF, '0); #1;
    checks++; if (gnt !== 4'b1001) begin errors++; $display("FAIL oor_gnt: got %b want 1001", gnt); end
    tick();
    put(0, BASE + SPAN, 1'b1, 4'hF, '0);
    put(3, BASE - 32'd4, 1'b1, 4'hF, '0);
    tick();
    checks++;
    if (rv !== 4'b1001 || ropc !== 4'b1001) begin
      errors++; $display("FAIL oor_wr_resp: valid=%b opc=%b want 1001/1001", rv, ropc);
    end
    put(0, BASE, 1'b1, 4'hF, '0);
    put(3, BASE + 32'hFC, 1'b1, 4'hF, '0);
    tick();
    checks++;
    if (rv !== 4'b1001 || ropc !== 4'b1001 || rdata[0] !== '0 || rdata[3] !== '0) begin
      errors++;
      $display("FAIL oor_rd_resp: valid=%b opc=%b d0=%h d3=%h want 1001/1001/0/0", rv, ropc,
               rdata[0], rdata[3]);
    end
    tick();
    checks++;
    if (rv !== 4'b1001 || ropc !== '0 || rdata[0] !== 32'hA5A5_A5A5 || rdata[3] !== 32'h5A5A_C3C3)
    begin
      errors++;
      $display("FAIL oor_no_modify: valid=%b opc=%b d0=%h d3=%h want 1001/0000/a5a5a5a5/5a5ac3c3",
               rv, ropc, rdata[0], rdata[3]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    resp_t e;
    clear_ring();
    for (int c = 0; c < 16 + RL + 1; c++) begin
      if (c < 16) begin
        for (int b = 0; b < NB; b++) put(b, waddr(c % 8, b), c >= 8, 4'hF, $urandom);
        #1;
        checks++;
        if (gnt !== '1) begin errors++; $display("FAIL b2b_gnt c%0d: got %b want 1111", c, gnt); end
      end
      tick();
      for (int b = 0; b < NB; b++) begin
        e = ring[cyc % 8][b];
        ring[cyc % 8][b].v = 1'b0;
        checks++;
        if (rv[b] !== e.v || (e.v && ropc[b] !== e.opc) || (e.v && e.chk && rdata[b] !== e.data))
        begin
          errors++;
          $display("FAIL b2b bank%0d cyc%0d: valid=%b opc=%b data=%h want valid=%b opc=%b data=%h",
                   b, cyc, rv[b], ropc[b], rdata[b], e.v, e.opc, e.data);
        end
      end
    end
  endtask

  task automatic test_random();
    resp_t       e;
    int          idx, sel;
    logic [31:0] a;
    logic [3:0]  bb;
    clear_ring();
    for (int c = 0; c < 300 + RL + 1; c++) begin
      if (c < 300) begin
        for (int b = 0; b < NB; b++) begin
          if ($urandom_range(0, 9) < 7) begin
            idx = $urandom_range(0, BW - 1);
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = BASE + SPAN + 32'(($urandom_range(0, 63) * NB + b) * 4);
            else if (sel == 1) a = BASE - 32'(NB * 4) + 32'(b * 4);
            else               a = waddr(idx, b);
            bb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            put(b, a, 1'($urandom), bb, $urandom);
          end
        end
      end
      tick();
      for (int b = 0; b < NB; b++) begin
        e = ring[cyc % 8][b];
        ring[cyc % 8][b].v = 1'b0;
        checks++;
        if (rv[b] !== e.v || (e.v && ropc[b] !== e.opc) || (e.v && e.chk && rdata[b] !== e.data))
        begin
          errors++;
          $display("FAIL rand bank%0d cyc%0d: valid=%b opc=%b data=%h want valid=%b opc=%b data=%h",
                   b, cyc, rv[b], ropc[b], rdata[b], e.v, e.opc, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    int k;
    for (int b = 0; b < NB; b++) put(b, waddr(b, b), 1'b1, 4'hF, '0);
    tick();
    rst = 1'b1;
    for (int b = 0; b < NB; b++) put(b, waddr(b, b), 1'b1, 4'hF, '0);
    tick();
    checks++;
    if (rv !== '0 || ropc !== '0 || rdata !== '0 || idone !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight: valid=%b opc=%b data=%h done=%b, want all 0", rv, ropc, rdata,
               idone);
    end
    req = '1; #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt2: got %b want 0", gnt); end
    rst = 1'b0; req = '0;
    for (int t = 0; t <= RL; t++) begin
      tick();
      checks++; if (rv !== '0) begin errors++; $display("FAIL stale_valid t%0d: got %b", t, rv); end
    end
`ifdef L2_INIT_ZERO_EN
    rst = 1'b1; tick();
    rst = 1'b0;
    k = 0;
    while (idone !== 1'b1 && k < 2 * BW) begin tick(); k++; end
    checks++; if (k != BW) begin errors++; $display("FAIL sweep_restart: %0d cycles want %0d", k, BW); end
    rst = 1'b1; tick();
    rst = 1'b0; tm = 1'b1; tick();
    checks++; if (idone !== 1'b1) begin errors++; $display("FAIL test_mode: done=%b want 1", idone); end
    tm = 1'b0;
`else
    k = 0;
`endif
  endtask

  initial begin
    rst = 1'b1; tm = 1'b0; req = '0; wen = '1; be = '1; add = '0; wdata = '0;
    test_reset();
`ifdef L2_INIT_ZERO_EN
    test_zero_init();
`endif
    test_interleave();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
